l1_l2_req_arbiter: RTL

//  N-port L1->L2 request arbiter; replaces the fixed I/D point-to-point wiring into the L2 cache.

---
 rtl/l1l2_arb_pkg.sv | 29 ++
 rtl/l1_l2_req_arbiter_if.sv | 40 ++++
 rtl/l1l2_resp_fifo.sv | 50 +++++
 rtl/l1_l2_req_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/l1l2_arb_pkg.sv
// Shared constants, response-entry, request-payload and FSM types for the L1->L2 request arbiter.
package l1l2_arb_pkg;
  localparam int unsigned N_PORTS         = 3;
  localparam int unsigned L1_OFFSET_WIDTH = 2;
  localparam int unsigned LINE_W          = 32 * (1 << L1_OFFSET_WIDTH);
  localparam int unsigned OUTSTANDING     = 4;
  localparam int unsigned PID_W           = $clog2(N_PORTS);
  localparam int unsigned PTR_W           = $clog2(OUTSTANDING);
  localparam int unsigned CNT_W           = $clog2(OUTSTANDING + 1);

  typedef struct packed {
    logic             discard;
    logic [PID_W-1:0] port;
  } resp_entry_t;

  typedef struct packed {
    logic        wr;
    logic        suc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  size;
  } req_payload_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;
endpackage

// File: rtl/l1_l2_req_arbiter_if.sv
// L1 client and L2 bus bundle; slave = arbiter view, master = clients/L2 view.
interface l1_l2_req_arbiter_if
  import l1l2_arb_pkg::*;
();
  logic [N_PORTS-1:0]    l1_req;
  logic [N_PORTS-1:0]    l1_wr;
  logic [N_PORTS-1:0]    l1_SUC;
  logic [N_PORTS*32-1:0] l1_addr;
  logic [N_PORTS*32-1:0] l1_wdata;
  logic [N_PORTS*4-1:0]  l1_wstrb;
  logic [N_PORTS*2-1:0]  l1_size;
  logic [N_PORTS-1:0]    l1_flush;
  logic [N_PORTS-1:0]    l1_addrOK;
  logic [N_PORTS-1:0]    l1_dataOK;
  logic [LINE_W-1:0]     l1_rdata;
  logic                  l2_req;
  logic                  l2_wr;
  logic                  l2_SUC;
  logic [31:0]           l2_addr;
  logic [31:0]           l2_wdata;
  logic [3:0]            l2_wstrb;
  logic [1:0]            l2_size;
  logic                  l2_addrOK;
  logic                  l2_dataOK;
  logic [LINE_W-1:0]     l2_rdata;

  modport slave (
    input  l1_req, l1_wr, l1_SUC, l1_addr, l1_wdata, l1_wstrb, l1_size, l1_flush,
    input  l2_addrOK, l2_dataOK, l2_rdata,
    output l1_addrOK, l1_dataOK, l1_rdata,
    output l2_req, l2_wr, l2_SUC, l2_addr, l2_wdata, l2_wstrb, l2_size
  );

  modport master (
    output l1_req, l1_wr, l1_SUC, l1_addr, l1_wdata, l1_wstrb, l1_size, l1_flush,
    output l2_addrOK, l2_dataOK, l2_rdata,
    input  l1_addrOK, l1_dataOK, l1_rdata,
    input  l2_req, l2_wr, l2_SUC, l2_addr, l2_wdata, l2_wstrb, l2_size
  );
endinterface

// File: rtl/l1l2_resp_fifo.sv
// In-order FIFO of {discard, port} response entries with a per-port bulk discard-set.
module l1l2_resp_fifo
  import l1l2_arb_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  resp_entry_t        push_entry_i,
  input  logic               pop_i,
  input  logic [N_PORTS-1:0] flush_i,
  output resp_entry_t        head_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               full_o,
  output logic               empty_o
);
  resp_entry_t      mem_q [OUTSTANDING];
  resp_entry_t      mem_d [OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Stale slots may be marked too; they are overwritten on their next push.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < OUTSTANDING; i++) begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (flush_i[p] && (mem_q[i].port == PID_W'(p))) mem_d[i].discard = 1'b1;
      end
    end
    if (push_i) mem_d[wr_ptr_q] = push_entry_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < OUTSTANDING; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q <= mem_d;
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(OUTSTANDING));
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/l1_l2_req_arbiter.sv
// Round-robin N-port L1->L2 request arbiter with in-order response routing and per-port flush.
// Optional performance counters under `L1L2_ARB_PERF_EN.
module l1_l2_req_arbiter
  import l1l2_arb_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  l1_l2_req_arbiter_if.slave    bus,
  output logic                  arb_err_o
`ifdef L1L2_ARB_PERF_EN
  ,
  output logic [N_PORTS*32-1:0] perf_grant_cnt_o,
  output logic [31:0]           perf_full_cnt_o
`endif
);
  arb_state_e       state_q, state_d;
  logic [PID_W-1:0] rr_ptr_q, rr_ptr_d, gnt_q, gnt_d, sel;
  logic             sel_vld;
  req_payload_t     pl [N_PORTS];
  req_payload_t     issue_q, issue_d;
  logic             issue_disc_q, issue_disc_d;
  logic             arb_err_q;
  logic             push, pop, head_kill;
  resp_entry_t      push_entry, head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      pl[p].wr    = bus.l1_wr[p];
      pl[p].suc   = bus.l1_SUC[p];
      pl[p].addr  = bus.l1_addr[p*32 +: 32];
      pl[p].wdata = bus.l1_wdata[p*32 +: 32];
      pl[p].wstrb = bus.l1_wstrb[p*4 +: 4];
      pl[p].size  = bus.l1_size[p*2 +: 2];
    end
  end

  // First requesting port at or after rr_ptr.
  always_comb begin
    logic [PID_W-1:0] idx;
    idx     = '0;
    sel     = '0;
    sel_vld = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = PID_W'((32'(rr_ptr_q) + 32'(i)) % N_PORTS);
      if (!sel_vld && bus.l1_req[idx]) begin
        sel_vld = 1'b1;
        sel     = idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_vld && !fifo_full) state_d = ISSUE;
      ISSUE:   if (bus.l2_addrOK) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    gnt_d         = gnt_q;
    issue_d       = issue_q;
    issue_disc_d  = issue_disc_q;
    push          = 1'b0;
    push_entry    = '0;
    bus.l1_addrOK = '0;
    case (state_q)
      IDLE: begin
        if (sel_vld && !fifo_full) begin
          gnt_d        = sel;
          issue_d      = pl[sel];
          issue_disc_d = bus.l1_flush[sel];
        end
      end
      ISSUE: begin
        if (bus.l1_flush[gnt_q]) issue_disc_d = 1'b1;
        if (bus.l2_addrOK && !rst_i) begin
          bus.l1_addrOK[gnt_q] = 1'b1;
          push                 = 1'b1;
          push_entry.discard   = issue_disc_q | bus.l1_flush[gnt_q];
          push_entry.port      = gnt_q;
          rr_ptr_d = (gnt_q == PID_W'(N_PORTS - 1)) ? '0 : gnt_q + PID_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      issue_q      <= '0;
      issue_disc_q <= 1'b0;
      arb_err_q    <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      issue_q      <= issue_d;
      issue_disc_q <= issue_disc_d;
      if (bus.l2_dataOK && (fifo_count == '0)) arb_err_q <= 1'b1;
    end
  end

  // A flush arriving with the pop of its own entry still suppresses the response.
  always_comb begin
    pop           = bus.l2_dataOK && !fifo_empty && !rst_i;
    head_kill     = head.discard | bus.l1_flush[head.port];
    bus.l1_dataOK = '0;
    if (pop && !head_kill) bus.l1_dataOK[head.port] = 1'b1;
  end

  l1l2_resp_fifo u_resp_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (bus.l1_flush),
    .head_o       (head),
    .count_o      (fifo_count),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  assign bus.l1_rdata = rst_i ? '0 : bus.l2_rdata;
  assign bus.l2_req   = (state_q == ISSUE);
  assign bus.l2_wr    = issue_q.wr;
  assign bus.l2_SUC   = issue_q.suc;
  assign bus.l2_addr  = issue_q.addr;
  assign bus.l2_wdata = issue_q.wdata;
  assign bus.l2_wstrb = issue_q.wstrb;
  assign bus.l2_size  = issue_q.size;
  assign arb_err_o    = arb_err_q;

`ifdef L1L2_ARB_PERF_EN
  logic [31:0] grant_cnt_q [N_PORTS];
  logic [31:0] full_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < N_PORTS; p++) grant_cnt_q[p] <= '0;
      full_cnt_q <= '0;
    end else begin
      if (push) grant_cnt_q[gnt_q] <= grant_cnt_q[gnt_q] + 32'd1;
      if ((state_q == IDLE) && sel_vld && fifo_full) full_cnt_q <= full_cnt_q + 32'd1;
    end
  end

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) perf_grant_cnt_o[p*32 +: 32] = grant_cnt_q[p];
  end
  assign perf_full_cnt_o = full_cnt_q;
`endif
endmodule
